// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared constants for the sequenced 8-bit ALU: operand/op-select/counter
// widths, the sixteen op codes (OP_ADD .. OP_EQ) and the controller FSM
// state type. Imported by ALU_8b and alu_seq_ctrl.
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam int DATA_W  = 8;
    localparam int SEL_W   = 4;
    localparam int COUNT_W = 16;

    localparam logic [SEL_W-1:0] OP_ADD  = 4'b0000;
    localparam logic [SEL_W-1:0] OP_SUB  = 4'b0001;
    localparam logic [SEL_W-1:0] OP_MUL  = 4'b0010;
    localparam logic [SEL_W-1:0] OP_DIV  = 4'b0011;
    localparam logic [SEL_W-1:0] OP_SHL  = 4'b0100;
    localparam logic [SEL_W-1:0] OP_SHR  = 4'b0101;
    localparam logic [SEL_W-1:0] OP_ROL  = 4'b0110;
    localparam logic [SEL_W-1:0] OP_ROR  = 4'b0111;
    localparam logic [SEL_W-1:0] OP_AND  = 4'b1000;
    localparam logic [SEL_W-1:0] OP_OR   = 4'b1001;
    localparam logic [SEL_W-1:0] OP_XOR  = 4'b1010;
    localparam logic [SEL_W-1:0] OP_NOR  = 4'b1011;
    localparam logic [SEL_W-1:0] OP_NAND = 4'b1100;
    localparam logic [SEL_W-1:0] OP_XNOR = 4'b1101;
    localparam logic [SEL_W-1:0] OP_GT   = 4'b1110;
    localparam logic [SEL_W-1:0] OP_EQ   = 4'b1111;

    // IDLE accepts a request, EXEC runs the ALU for one cycle, HOLD presents
    // the registered result until the consumer takes it.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/ALU_8b.sv
// -----------------------------------------------------------------------------
// ALU_8b
// Purely combinational 8-bit ALU with the team op encoding.
// Ports:
//   A, B      [7:0] in  operands
//   ALU_Sel   [3:0] in  op code (OP_ADD .. OP_EQ from alu_pkg)
//   ALU_Out   [7:0] out result (multiply truncated to low 8 bits,
//                       compares return 0/1)
//   CarryOut        out carry out of the 9-bit unsigned add A+B, valid for
//                       every op; the caller decides when to use it
// -----------------------------------------------------------------------------
module ALU_8b
    import alu_pkg::*;
(
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    input  logic [SEL_W-1:0]  ALU_Sel,
    output logic [DATA_W-1:0] ALU_Out,
    output logic              CarryOut
);

    logic [DATA_W:0] sum;

    // One case per op code. Divide by zero returns 0 here only so the
    // datapath never sees an undefined value; the controller replaces
    // that result with its own divide-by-zero code.
    always_comb begin
        sum      = {1'b0, A} + {1'b0, B};
        CarryOut = sum[DATA_W];
        ALU_Out  = '0;
        case (ALU_Sel)
            OP_ADD:  ALU_Out = sum[DATA_W-1:0];
            OP_SUB:  ALU_Out = A - B;
            OP_MUL:  ALU_Out = A * B;
            OP_DIV:  ALU_Out = (B == '0) ? '0 : (A / B);
            OP_SHL:  ALU_Out = A << 1;
            OP_SHR:  ALU_Out = A >> 1;
            OP_ROL:  ALU_Out = {A[DATA_W-2:0], A[DATA_W-1]};
            OP_ROR:  ALU_Out = {A[0], A[DATA_W-1:1]};
            OP_AND:  ALU_Out = A & B;
            OP_OR:   ALU_Out = A | B;
            OP_XOR:  ALU_Out = A ^ B;
            OP_NOR:  ALU_Out = ~(A | B);
            OP_NAND: ALU_Out = ~(A & B);
            OP_XNOR: ALU_Out = ~(A ^ B);
            OP_GT:   ALU_Out = {{(DATA_W-1){1'b0}}, (A > B)};
            OP_EQ:   ALU_Out = {{(DATA_W-1){1'b0}}, (A == B)};
            default: ALU_Out = '0;
        endcase
    end

endmodule

// File: rtl/alu_seq_ctrl.sv
// -----------------------------------------------------------------------------
// alu_seq_ctrl
// Valid/ready wrapper around ALU_8b. A request is captured in IDLE, executed
// in EXEC (result and flags registered at the end of that cycle) and held in
// HOLD until the consumer accepts it, so out_valid rises exactly two cycles
// after the accept and at most one operation completes every three cycles.
//
// Ports:
//   clk                 in   single clock, rising edge
//   rst                 in   synchronous active-high reset
//   in_valid/in_ready   in/out  request handshake (in_ready only in IDLE)
//   A, B        [7:0]   in   operands
//   ALU_Sel     [3:0]   in   op code
//   UseAcc              in   (ALU_SEQ_ACCUM_EN only) use last delivered
//                            result in place of A, sampled at accept
//   out_valid/out_ready out/in  result handshake
//   ALU_Out     [7:0]   out  registered result
//   CarryOut            out  add carry, 0 for every other op
//   Zero                out  ALU_Out == 0 (forced 0 on divide by zero)
//   DivZero             out  divide with B == 0
//   OpCount     [15:0]  out  completed output handshakes, wraps
//
// Build option: define ALU_SEQ_ACCUM_EN to add the UseAcc port and the
// accumulator register holding the last delivered ALU_Out.
// -----------------------------------------------------------------------------
module alu_seq_ctrl
    import alu_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  A,
    input  logic [DATA_W-1:0]  B,
    input  logic [SEL_W-1:0]   ALU_Sel,
`ifdef ALU_SEQ_ACCUM_EN
    input  logic               UseAcc,
`endif
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  ALU_Out,
    output logic               CarryOut,
    output logic               Zero,
    output logic               DivZero,
    output logic [COUNT_W-1:0] OpCount
);

    state_t state;
    state_t next_state;

    logic [DATA_W-1:0] cap_a;
    logic [DATA_W-1:0] cap_b;
    logic [SEL_W-1:0]  cap_sel;
    logic [DATA_W-1:0] operand_a;

    logic [DATA_W-1:0] alu_res;
    logic              alu_carry;
    logic              div_by_zero;

    logic accept;
    logic deliver;

    assign accept  = in_valid && in_ready;
    assign deliver = out_valid && out_ready;

`ifdef ALU_SEQ_ACCUM_EN
    logic [DATA_W-1:0] acc;

    // Accumulator holds the last result the consumer actually took, so an
    // operation discarded by reset never reaches it.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
        end else if (deliver) begin
            acc <= ALU_Out;
        end
    end

    assign operand_a = UseAcc ? acc : A;
`else
    assign operand_a = A;
`endif

    // State register; reset wins over any handshake in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and handshake decode. in_ready is tied to IDLE, so a
    // request arriving during EXEC or HOLD, including the delivery cycle,
    // is simply not taken.
    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    next_state = EXEC;
                end
            end
            EXEC: begin
                next_state = HOLD;
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Request capture: operands and op code are frozen at accept so the
    // inputs may change freely while the operation is in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            cap_a   <= '0;
            cap_b   <= '0;
            cap_sel <= OP_ADD;
        end else if (accept) begin
            cap_a   <= operand_a;
            cap_b   <= B;
            cap_sel <= ALU_Sel;
        end
    end

    ALU_8b u_alu (
        .A        (cap_a),
        .B        (cap_b),
        .ALU_Sel  (cap_sel),
        .ALU_Out  (alu_res),
        .CarryOut (alu_carry)
    );

    assign div_by_zero = (cap_sel == OP_DIV) && (cap_b == '0);

    // Result register, loaded only at the end of EXEC and otherwise held,
    // which keeps the outputs stable however long the consumer stalls.
    // Divide by zero reports 8'hFF with Zero cleared; carry is only
    // meaningful for add.
    always_ff @(posedge clk) begin
        if (rst) begin
            ALU_Out  <= '0;
            CarryOut <= 1'b0;
            Zero     <= 1'b0;
            DivZero  <= 1'b0;
        end else if (state == EXEC) begin
            if (div_by_zero) begin
                ALU_Out  <= '1;
                CarryOut <= 1'b0;
                Zero     <= 1'b0;
                DivZero  <= 1'b1;
            end else begin
                ALU_Out  <= alu_res;
                CarryOut <= (cap_sel == OP_ADD) ? alu_carry : 1'b0;
                Zero     <= (alu_res == '0);
                DivZero  <= 1'b0;
            end
        end
    end

    // Completed-operation counter; wraps naturally at its width.
    always_ff @(posedge clk) begin
        if (rst) begin
            OpCount <= '0;
        end else if (deliver) begin
            OpCount <= OpCount + 1'b1;
        end
    end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_alu_seq_ctrl
// Directed and randomized checks of alu_seq_ctrl against a behavioural model
// of the op table, the three-cycle handshake rhythm and the completion count.
// Define ALU_SEQ_ACCUM_EN to include the accumulator port and its test.
// Define TB_FULL_WRAP to run the 65536-operation counter wrap (about 200k
// cycles); the default build runs a shorter random stream.
// -----------------------------------------------------------------------------
module tb_alu_seq_ctrl;

    typedef struct packed {
        logic [7:0] out;
        logic       carry;
        logic       zero;
        logic       dz;
    } res_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  A = 8'h00;
    logic [7:0]  B = 8'h00;
    logic [3:0]  ALU_Sel = 4'h0;
`ifdef ALU_SEQ_ACCUM_EN
    logic        UseAcc = 1'b0;
`endif
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  ALU_Out;
    logic        CarryOut;
    logic        Zero;
    logic        DivZero;
    logic [15:0] OpCount;

    int   checks = 0;
    int   errors = 0;
    int   exp_count = 0;
    logic [7:0] acc_model = 8'h00;
    res_t pending;

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    alu_seq_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .ALU_Sel   (ALU_Sel),
`ifdef ALU_SEQ_ACCUM_EN
        .UseAcc    (UseAcc),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ALU_Out   (ALU_Out),
        .CarryOut  (CarryOut),
        .Zero      (Zero),
        .DivZero   (DivZero),
        .OpCount   (OpCount)
    );

    // Hard stop in case something stalls the sequence below.
    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference op table written as integer arithmetic.
    function automatic res_t refAlu(input int a, input int b, input int sel);
        int   r;
        res_t e;
        e.carry = 1'b0;
        e.dz    = 1'b0;
        case (sel)
            0:  begin r = a + b; e.carry = (r > 255); end
            1:  r = a - b;
            2:  r = a * b;
            3:  if (b == 0) begin r = 255; e.dz = 1'b1; end else r = a / b;
            4:  r = a * 2;
            5:  r = a / 2;
            6:  r = a * 2 + a / 128;
            7:  r = a / 2 + (a % 2) * 128;
            8:  r = a & b;
            9:  r = a | b;
            10: r = a ^ b;
            11: r = ~(a | b);
            12: r = ~(a & b);
            13: r = ~(a ^ b);
            14: r = (a > b) ? 1 : 0;
            default: r = (a == b) ? 1 : 0;
        endcase
        e.out  = 8'(r & 255);
        e.zero = !e.dz && (e.out == 8'h00);
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkResult(input string tag);
        checkOutput({tag, "_out"},   32'(ALU_Out),  32'(pending.out));
        checkOutput({tag, "_carry"}, 32'(CarryOut), 32'(pending.carry));
        checkOutput({tag, "_zero"},  32'(Zero),     32'(pending.zero));
        checkOutput({tag, "_divz"},  32'(DivZero),  32'(pending.dz));
    endtask

    task automatic resetDut();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        exp_count = 0;
        acc_model = 8'h00;
    endtask

    // Accepts one request and walks it to HOLD, checking the two-cycle
    // accept-to-out_valid latency and the result on arrival.
    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b,
                                 input logic [3:0] sel, input bit use_acc);
        int n = 0;
        while (in_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checkOutput("in_ready_before_accept", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        A = a;
        B = b;
        ALU_Sel = sel;
`ifdef ALU_SEQ_ACCUM_EN
        UseAcc = use_acc;
`endif
        pending = refAlu(int'(use_acc ? acc_model : a), int'(b), int'(sel));
        tick();
        in_valid = 1'b0;
        A = 8'($urandom);
        B = 8'($urandom);
        ALU_Sel = 4'($urandom);
`ifdef ALU_SEQ_ACCUM_EN
        UseAcc = 1'b0;
`endif
        checkOutput("exec_out_valid", 32'(out_valid), 32'd0);
        checkOutput("exec_in_ready",  32'(in_ready),  32'd0);
        tick();
        checkOutput("hold_out_valid", 32'(out_valid), 32'd1);
        checkResult("hold");
    endtask

    // Stalls the consumer, throwing ignored requests at the block, then
    // completes the handshake with a request still offered.
    task automatic collectOutput(input int stall);
        out_ready = 1'b0;
        for (int i = 0; i < stall; i++) begin
            in_valid = 1'b1;
            A = 8'($urandom);
            B = 8'($urandom);
            tick();
            checkOutput("stall_out_valid", 32'(out_valid), 32'd1);
            checkOutput("stall_in_ready",  32'(in_ready),  32'd0);
            checkOutput("stall_count",     32'(OpCount),   32'(exp_count));
            checkResult("stall");
        end
        in_valid = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        out_ready = 1'b0;
        exp_count = (exp_count + 1) % 65536;
        acc_model = pending.out;
        checkOutput("done_out_valid", 32'(out_valid), 32'd0);
        checkOutput("done_in_ready",  32'(in_ready),  32'd1);
        checkOutput("done_count",     32'(OpCount),   32'(exp_count));
    endtask

    // Continuous traffic with in_valid and out_ready held high; the model
    // expects an accept, an execute and a delivery on every third cycle.
    task automatic streamOps(input int n_ops);
        int   phase = 0;
        bit   ua;
        logic [7:0] a, b;
        logic [3:0] sel;
        out_ready = 1'b1;
        for (int c = 0; c < 3 * n_ops; c++) begin
            a   = 8'($urandom);
            b   = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            sel = 4'($urandom);
            ua  = 1'b0;
`ifdef ALU_SEQ_ACCUM_EN
            ua = 1'($urandom_range(0, 1));
            UseAcc = ua;
`endif
            in_valid = 1'b1;
            A = a;
            B = b;
            ALU_Sel = sel;
            checkOutput("rnd_in_ready",  32'(in_ready),  32'(phase == 0));
            checkOutput("rnd_out_valid", 32'(out_valid), 32'(phase == 2));
            if (phase == 0) begin
                pending = refAlu(int'(ua ? acc_model : a), int'(b), int'(sel));
            end
            if (phase == 2) begin
                checkResult("rnd");
                exp_count = (exp_count + 1) % 65536;
                acc_model = pending.out;
            end
            tick();
            phase = (phase + 1) % 3;
            if (phase == 0) begin
                checkOutput("rnd_count", 32'(OpCount), 32'(exp_count));
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
`ifdef ALU_SEQ_ACCUM_EN
        UseAcc = 1'b0;
`endif
    endtask

    initial begin
        // Reset state.
        resetDut();
        checkOutput("rst_in_ready",  32'(in_ready),  32'd1);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_alu_out",   32'(ALU_Out),   32'd0);
        checkOutput("rst_carry",     32'(CarryOut),  32'd0);
        checkOutput("rst_zero",      32'(Zero),      32'd0);
        checkOutput("rst_divz",      32'(DivZero),   32'd0);
        checkOutput("rst_count",     32'(OpCount),   32'd0);

        // Reset while HOLD offers a result that the consumer accepts.
        applyStimulus(8'hF0, 8'h20, 4'b0000, 1'b0);
        out_ready = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        out_ready = 1'b0;
        exp_count = 0;
        acc_model = 8'h00;
        checkOutput("rsthold_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rsthold_in_ready",  32'(in_ready),  32'd1);
        checkOutput("rsthold_count",     32'(OpCount),   32'd0);
        checkOutput("rsthold_alu_out",   32'(ALU_Out),   32'd0);

        // Add with carry out.
        applyStimulus(8'hF0, 8'h20, 4'b0000, 1'b0);
        checkOutput("add_f0_20_out",   32'(ALU_Out),  32'h10);
        checkOutput("add_f0_20_carry", 32'(CarryOut), 32'd1);
        checkOutput("add_f0_20_zero",  32'(Zero),     32'd0);
        collectOutput(0);

        // Divide by zero, then a normal divide.
        applyStimulus(8'h40, 8'h00, 4'b0011, 1'b0);
        checkOutput("div0_out",  32'(ALU_Out), 32'hFF);
        checkOutput("div0_divz", 32'(DivZero), 32'd1);
        checkOutput("div0_zero", 32'(Zero),    32'd0);
        collectOutput(1);
        applyStimulus(8'h40, 8'h04, 4'b0011, 1'b0);
        checkOutput("div_out",  32'(ALU_Out), 32'h10);
        checkOutput("div_divz", 32'(DivZero), 32'd0);
        collectOutput(0);

        // XOR to zero with a five-cycle consumer stall.
        applyStimulus(8'h5A, 8'h5A, 4'b1010, 1'b0);
        checkOutput("xor_zero", 32'(Zero),    32'd1);
        checkOutput("xor_out",  32'(ALU_Out), 32'd0);
        collectOutput(5);
        checkOutput("xor_count", 32'(OpCount), 32'd4);

`ifdef ALU_SEQ_ACCUM_EN
        // Accumulator chaining: (3 + 4) * 2.
        resetDut();
        applyStimulus(8'h03, 8'h04, 4'b0000, 1'b0);
        collectOutput(0);
        applyStimulus(8'($urandom), 8'h02, 4'b0010, 1'b1);
        checkOutput("acc_mul_out", 32'(ALU_Out), 32'h0E);
        collectOutput(0);
`endif

`ifdef TB_FULL_WRAP
        // Full counter wrap from reset.
        resetDut();
        streamOps(65536);
        checkOutput("opcount_wrap", 32'(OpCount), 32'd0);
`else
        streamOps(400);
        checkOutput("stream_count", 32'(OpCount), 32'(exp_count));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
